r200memarb: RTL and testbench
=============================

# r200memarb

Unified-memory arbiter for the r200 pipeline. It shares one single-ported memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage), and sequences each access through a req/ack handshake with a variable-latency memory. Data has priority, with a bounded-starvation guarantee for fetch and a watchdog that abandons hung accesses. It sits between `r200if`/`r200mem` and the memory model; the pipeline stalls on the ready outputs.

## Interface
- `STARVE_MAX`, 4: consecutive data grants allowed while fetch waits (1..15).
- `TIMEOUT`, 64: cycles in a busy state without `m_ack` before abort (2..255).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request; `if_addr` stable while high.
- `if_addr` in 32: fetch address.
- `if_ready` out 1: fetch completion strobe.
- `if_rdata` out 32: fetched word; valid only while `if_ready`=1.
- `d_req` in 1: data request.
- `d_we` in 1: 1=write, 0=read.
- `d_addr` in 32: data address.
- `d_wdata` in 32: write data.
- `d_ready` out 1: data completion strobe.
- `d_rdata` out 32: read data; valid only while `d_ready`=1 and the access is a read.
- `m_req` out 1: memory request, registered.
- `m_we` out 1: memory write enable, registered.
- `m_addr` out 32: memory address, registered.
- `m_wdata` out 32: memory write data, registered.
- `m_rdata` in 32: memory read data, valid with `m_ack`.
- `m_ack` in 1: memory completion, 1-cycle pulse.
- `err` out 1: sticky timeout flag.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D. Reset state is IDLE.
- **IDLE arbitration**
  - No requests: stay in IDLE.
  - One request: grant it.
  - Both requests: grant data, unless `streak`==`STARVE_MAX`, in which case grant fetch.
- **On grant**
  - Register `m_addr`, `m_we` (0 for fetch, `d_we` for data) and `m_wdata`, and set `m_req`=1.
  - Go to BUSY_I or BUSY_D.
  - The inputs are sampled only at grant. Dropping `req` after grant does not abort the access.
- **BUSY_x with `m_ack`=1**
  - Pulse `x_ready`=1 in the same cycle (combinational).
  - `x_rdata`=`m_rdata` passthrough.
  - Next state IDLE; `m_req` and `m_we` clear.
  - The requester must drop or change `req` in the cycle after ready.
- **`streak` (4 bits)**
  - Increments on a data grant made while `if_req`=1.
  - Clears on any fetch grant.
  - Holds on a data grant with `if_req`=0.
  - Saturates at `STARVE_MAX`.
- **Watchdog `wcnt` (8 bits)**
  - Clears on entering BUSY and increments each BUSY cycle without ack.
  - When `wcnt`==`TIMEOUT`-1 with no ack:
    - Pulse `x_ready` with `x_rdata`=32'h0.
    - Set `err`; it stays 1 until reset.
    - Drop `m_req` and return to IDLE.
    - Writes are lost.
  - `m_ack` arriving in IDLE is ignored.
- `m_ack` and timeout in the same cycle: the ack wins, real data is returned, and `err` is unchanged.
- **Reset (any time, including mid-access)**
  - All outputs go low or zero immediately: `m_req`, `m_we`, `m_addr`, `m_wdata`, `err`, `if_ready`, `d_ready`, rdata.
  - `streak` and `wcnt` clear. A pending access is discarded.

## Timing
- A request seen in IDLE at cycle 0 gives `m_req`=1 from cycle 1.
- With `m_ack` in cycle k≥1, ready is asserted in cycle k and the FSM is in IDLE at k+1.
- Minimum access is 2 cycles. Back-to-back grants have 1 IDLE bubble, so peak throughput is one access per 2 cycles plus memory latency.
- The ready outputs are never both 1. At most one of BUSY_I and BUSY_D is active.
- The timeout ready pulse occurs `TIMEOUT` cycles after grant.

## Structure
- State encodings (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2) and the default `STARVE_MAX`/`TIMEOUT` values are `define`d in `cpu.vh`.
- One sub-module, `r200memarb_wdog`: the 8-bit watchdog counter.
  - Inputs: `clr`, `en`.
  - Output: `expire`.
- Arbitration and the FSM stay in the top module.

## Test plan
- Fetch only, `if_addr`=0x100, memory ack at latency 3 with 0xDEADBEEF: `m_req` is high in cycles 1–3 with `m_addr`=0x100 and `m_we`=0. `if_ready` and `if_rdata`=0xDEADBEEF in cycle 3.
- Simultaneous `if_req`/`d_req` (d write 0x200←0x55): data is granted first (`m_we`=1, `m_wdata`=0x55), then fetch after 1 IDLE bubble.
- Continuous `d_req` with `if_req` held, `STARVE_MAX`=4: exactly 4 data grants, then 1 fetch grant, then `streak` is 0 and data resumes.
- No `m_ack`, `TIMEOUT`=64: `d_ready` pulses 64 cycles after grant with `d_rdata`=0, `err`=1 and stays 1, `m_req`=0 the next cycle.
- `m_ack` in the timeout cycle with 0x1234: ready with data 0x1234 and `err` stays 0.
- Reset asserted in BUSY_D, then released: all outputs are 0 asynchronously, the FSM is in IDLE, a stale `m_ack` is ignored, and the next request is granted normally.

Source files
------------

// File: rtl/r200memarb_pkg.sv
//------------------------------------------------------------------------------
// r200memarb_pkg
//   Shared encodings and defaults for the r200 unified-memory arbiter.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef R200_CPU_VH
`define R200_CPU_VH
`define R200_ST_IDLE    2'd0
`define R200_ST_BUSY_I  2'd1
`define R200_ST_BUSY_D  2'd2
`define R200_STARVE_MAX 4
`define R200_TIMEOUT    64
`endif

package r200memarb_pkg;

    localparam logic [1:0] c_st_idle   = `R200_ST_IDLE;
    localparam logic [1:0] c_st_busy_i = `R200_ST_BUSY_I;
    localparam logic [1:0] c_st_busy_d = `R200_ST_BUSY_D;

endpackage

`default_nettype wire

// File: rtl/r200memarb_wdog.sv
//------------------------------------------------------------------------------
// r200memarb_wdog
//   8-bit watchdog; expire fires on the TIMEOUT-th enabled cycle after clr.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module r200memarb_wdog #(
    parameter int unsigned TIMEOUT = `R200_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [7:0] c_last = 8'(TIMEOUT - 1);

    logic [7:0] r_wcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wcnt <= '0;
        end else if (clr) begin
            r_wcnt <= '0;
        end else if (en) begin
            r_wcnt <= r_wcnt + 8'd1;
        end
    end

    assign expire = en && (r_wcnt == c_last);

endmodule

`default_nettype wire

// File: rtl/r200memarb.sv
//------------------------------------------------------------------------------
// r200memarb
//   Shares one single-ported memory between fetch and data requesters.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module r200memarb
    import r200memarb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = `R200_STARVE_MAX,
    parameter int unsigned TIMEOUT    = `R200_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        err
);

    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_streak;
    logic        r_m_req;
    logic        r_m_we;
    logic [31:0] r_m_addr;
    logic [31:0] r_m_wdata;
    logic        r_err;
    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_busy;
    logic        w_done;
    logic        w_expire;

    assign w_busy = (r_state == c_st_busy_i) || (r_state == c_st_busy_d);
    // Ack gates the watchdog enable, so an ack in the expiry cycle wins.
    assign w_done = w_busy && (m_ack || w_expire);

    r200memarb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_grant_i | w_grant_d),
        .en     (w_busy & ~m_ack),
        .expire (w_expire)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (d_req && (!if_req || (r_streak != c_starve_max))) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = c_st_busy_d;
                end else if (if_req) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = c_st_busy_i;
                end
            end
            c_st_busy_i, c_st_busy_d: begin
                if (w_done) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_st_idle;
            r_streak  <= '0;
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_i) begin
                r_m_req   <= 1'b1;
                r_m_we    <= 1'b0;
                r_m_addr  <= if_addr;
                r_m_wdata <= '0;
                r_streak  <= '0;
            end else if (w_grant_d) begin
                r_m_req   <= 1'b1;
                r_m_we    <= d_we;
                r_m_addr  <= d_addr;
                r_m_wdata <= d_wdata;
                if (if_req && (r_streak != c_starve_max)) begin
                    r_streak <= r_streak + 4'd1;
                end
            end else if (w_done) begin
                r_m_req <= 1'b0;
                r_m_we  <= 1'b0;
            end
            if (w_expire) begin
                r_err <= 1'b1;
            end
        end
    end

    assign if_ready = (r_state == c_st_busy_i) && w_done;
    assign d_ready  = (r_state == c_st_busy_d) && w_done;
    assign if_rdata = (if_ready && m_ack) ? m_rdata : '0;
    assign d_rdata  = (d_ready && m_ack) ? m_rdata : '0;

    assign m_req   = r_m_req;
    assign m_we    = r_m_we;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_r200memarb.sv
//------------------------------------------------------------------------------
// tb_r200memarb
//   Directed self-checking bench for the r200 memory arbiter.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_r200memarb;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        err;

    int n_total = 0;
    int n_pass  = 0;

    r200memarb #(
        .STARVE_MAX (4),
        .TIMEOUT    (64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ready (if_ready),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ready  (d_ready),
        .d_rdata  (d_rdata),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ack    (m_ack),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow a few units later.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        m_rdata = '0;
        m_ack   = 1'b0;

        nxt(); nxt();
        #4;
        check("rst_m_req", m_req, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_err", err, 0);
        check("rst_state", dut.r_state, 0);
        nxt();
        rst = 1'b1;
        nxt();

        // Fetch only, ack at latency 3
        if_req = 1'b1; if_addr = 32'h100;
        #4;
        check("f_c0_m_req", m_req, 0);
        nxt(); #4;
        check("f_c1_m_req", m_req, 1);
        check("f_c1_m_addr", m_addr, 32'h100);
        check("f_c1_m_we", m_we, 0);
        check("f_c1_if_ready", if_ready, 0);
        nxt(); #4;
        check("f_c2_m_req", m_req, 1);
        nxt();
        m_ack = 1'b1; m_rdata = 32'hDEADBEEF;
        #4;
        check("f_c3_if_ready", if_ready, 1);
        check("f_c3_if_rdata", if_rdata, 32'hDEADBEEF);
        check("f_c3_d_ready", d_ready, 0);
        check("f_c3_m_req", m_req, 1);
        nxt();
        m_ack = 1'b0; if_req = 1'b0;
        #4;
        check("f_c4_m_req", m_req, 0);
        check("f_c4_state", dut.r_state, 0);
        check("f_c4_if_ready", if_ready, 0);

        // Simultaneous requests: data first, fetch after one bubble
        nxt();
        if_req = 1'b1; if_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h55;
        nxt(); #4;
        check("b_d_m_addr", m_addr, 32'h200);
        check("b_d_m_we", m_we, 1);
        check("b_d_m_wdata", m_wdata, 32'h55);
        m_ack = 1'b1; m_rdata = 32'h0;
        #1;
        check("b_d_ready", d_ready, 1);
        check("b_d_if_ready", if_ready, 0);
        nxt();
        m_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
        #4;
        check("b_bubble_m_req", m_req, 0);
        check("b_bubble_state", dut.r_state, 0);
        nxt(); #4;
        check("b_i_m_addr", m_addr, 32'h300);
        check("b_i_m_we", m_we, 0);
        check("b_i_state", dut.r_state, 1);
        m_ack = 1'b1; m_rdata = 32'hCAFE0001;
        #1;
        check("b_i_if_ready", if_ready, 1);
        check("b_i_if_rdata", if_rdata, 32'hCAFE0001);
        check("b_i_d_ready", d_ready, 0);
        nxt();
        m_ack = 1'b0; if_req = 1'b0;

        // Starvation bound: 4 data grants, 1 fetch, then data again
        nxt();
        if_req = 1'b1; if_addr = 32'h400;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        for (int i = 0; i < 6; i++) begin
            nxt(); #4;
            check($sformatf("s%0d_m_addr", i), m_addr, (i == 4) ? 32'h400 : 32'h500);
            if (i == 3) check("s3_streak", dut.r_streak, 4);
            if (i == 4) check("s4_streak", dut.r_streak, 0);
            if (i == 5) check("s5_streak", dut.r_streak, 1);
            m_ack = 1'b1; m_rdata = 32'hA0 + i;
            #1;
            check($sformatf("s%0d_if_ready", i), if_ready, (i == 4) ? 1 : 0);
            check($sformatf("s%0d_d_ready", i), d_ready, (i == 4) ? 0 : 1);
            nxt();
            m_ack = 1'b0;
            if (i == 5) begin
                if_req = 1'b0; d_req = 1'b0;
            end
            #4;
            check($sformatf("s%0d_idle_m_req", i), m_req, 0);
        end

        // Ack lands exactly in the timeout cycle: ack wins
        nxt();
        if_req = 1'b1; if_addr = 32'h900;
        for (int c = 1; c <= 64; c++) begin
            nxt();
            if (c == 1) if_req = 1'b0;
            if (c == 64) begin
                m_ack = 1'b1; m_rdata = 32'h1234;
            end
            #4;
            if (c == 64) begin
                check("ta_if_ready", if_ready, 1);
                check("ta_if_rdata", if_rdata, 32'h1234);
            end
        end
        nxt();
        m_ack = 1'b0;
        #4;
        check("ta_err", err, 0);
        check("ta_m_req", m_req, 0);

        // No ack: watchdog abort 64 cycles after grant
        nxt();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h600; d_wdata = 32'h77;
        for (int c = 1; c <= 64; c++) begin
            nxt();
            if (c == 1) begin
                d_req = 1'b0; d_we = 1'b0;
            end
            #4;
            if (c == 63) begin
                check("to_c63_d_ready", d_ready, 0);
                check("to_c63_m_req", m_req, 1);
            end
            if (c == 64) begin
                check("to_c64_d_ready", d_ready, 1);
                check("to_c64_d_rdata", d_rdata, 0);
            end
        end
        nxt(); #4;
        check("to_err", err, 1);
        check("to_m_req", m_req, 0);
        check("to_state", dut.r_state, 0);
        nxt();
        m_ack = 1'b1; m_rdata = 32'hBAD;
        #4;
        check("to_stale_d_ready", d_ready, 0);
        check("to_stale_if_ready", if_ready, 0);
        check("to_err_sticky", err, 1);
        nxt();
        m_ack = 1'b0;

        // Reset in the middle of a data access
        nxt();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h700; d_wdata = 32'h99;
        nxt(); #4;
        check("r_busy_state", dut.r_state, 2);
        #1;
        rst = 1'b0; m_ack = 1'b1; m_rdata = 32'h5A5A;
        #1;
        check("r_m_req", m_req, 0);
        check("r_m_we", m_we, 0);
        check("r_m_addr", m_addr, 0);
        check("r_m_wdata", m_wdata, 0);
        check("r_err", err, 0);
        check("r_d_ready", d_ready, 0);
        check("r_d_rdata", d_rdata, 0);
        check("r_state", dut.r_state, 0);
        nxt();
        rst = 1'b1; d_req = 1'b0; d_we = 1'b0;
        #4;
        check("r_stale_d_ready", d_ready, 0);
        check("r_stale_m_req", m_req, 0);
        nxt();
        m_ack = 1'b0;
        if_req = 1'b1; if_addr = 32'h800;
        nxt(); #4;
        check("r_new_m_req", m_req, 1);
        check("r_new_m_addr", m_addr, 32'h800);
        m_ack = 1'b1; m_rdata = 32'h600D;
        #1;
        check("r_new_if_rdata", if_rdata, 32'h600D);
        nxt();
        m_ack = 1'b0; if_req = 1'b0;
        nxt();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
